// File: rtl/controlador_display_7_seg_if.sv
// Display bus: four hex nibbles from the datapath, anode and segment pins to the board.
interface controlador_display_7_seg_if;
    logic [3:0] i_Datos1;
    logic [3:0] i_Datos2;
    logic [3:0] i_Datos3;
    logic [3:0] i_Datos4;
    logic [3:0] o_Anodo;
    logic [6:0] o_Segmentos;

    modport master (
        output i_Datos1, i_Datos2, i_Datos3, i_Datos4,
        input  o_Anodo, o_Segmentos
    );

    modport slave (
        input  i_Datos1, i_Datos2, i_Datos3, i_Datos4,
        output o_Anodo, o_Segmentos
    );
endinterface

// File: rtl/controlador_display_7_seg.sv
// Time-multiplexed 4-digit common-anode seven-segment driver.
// Each digit stays lit for P_DIV cycles; anodes and segments are active-low.
module controlador_display_7_seg #(
    parameter int unsigned P_DIV = 100000
) (
    input  logic                          i_Clk,
    input  logic                          i_Rst,
    controlador_display_7_seg_if.slave    bus
);

    localparam int unsigned     CNT_W    = (P_DIV > 1) ? $clog2(P_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       anodo_q, anodo_d;
    logic [6:0]       seg_q, seg_d;
    logic [3:0]       nib_c;

    // Hex to active-low {g,f,e,d,c,b,a}
    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Prescaler, digit select and next output pattern
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
        nib_c = bus.i_Datos1;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end
        case (idx_q)
            2'd0:    nib_c = bus.i_Datos1;
            2'd1:    nib_c = bus.i_Datos2;
            2'd2:    nib_c = bus.i_Datos3;
            default: nib_c = bus.i_Datos4;
        endcase
        anodo_d = ~(4'b0001 << idx_q);
        seg_d   = decode(nib_c);
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            anodo_q <= 4'b1111;
            seg_q   <= 7'b1111111;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            anodo_q <= anodo_d;
            seg_q   <= seg_d;
        end
    end

    assign bus.o_Anodo     = anodo_q;
    assign bus.o_Segmentos = seg_q;

endmodule

// File: tb/tb_controlador_display_7_seg.sv
// Directed bench for controlador_display_7_seg with P_DIV=4.
module tb_controlador_display_7_seg;

    localparam int unsigned P_DIV = 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    int   k;
    int   run_len;
    logic [3:0] prev_an;

    logic [6:0] seg_tbl [16];
    logic [3:0] an_tbl  [4];

    controlador_display_7_seg_if bus ();

    controlador_display_7_seg #(.P_DIV(P_DIV)) dut (
        .i_Clk (clk),
        .i_Rst (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %b expected %b (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance one edge and settle; k counts edges since reset release
    task automatic tick();
        @(posedge clk);
        #1;
        k = k + 1;
    endtask

    function automatic int digit_of(input int edge_n);
        return ((edge_n - 1) / int'(P_DIV)) % 4;
    endfunction

    task automatic set_data(input logic [3:0] d1, input logic [3:0] d2,
                            input logic [3:0] d3, input logic [3:0] d4);
        bus.i_Datos1 = d1;
        bus.i_Datos2 = d2;
        bus.i_Datos3 = d3;
        bus.i_Datos4 = d4;
    endtask

    initial begin
        logic [3:0] nib [4];
        seg_tbl[0]  = 7'b1000000; seg_tbl[1]  = 7'b1111001;
        seg_tbl[2]  = 7'b0100100; seg_tbl[3]  = 7'b0110000;
        seg_tbl[4]  = 7'b0011001; seg_tbl[5]  = 7'b0010010;
        seg_tbl[6]  = 7'b0000010; seg_tbl[7]  = 7'b1111000;
        seg_tbl[8]  = 7'b0000000; seg_tbl[9]  = 7'b0010000;
        seg_tbl[10] = 7'b0001000; seg_tbl[11] = 7'b0000011;
        seg_tbl[12] = 7'b1000110; seg_tbl[13] = 7'b0100001;
        seg_tbl[14] = 7'b0000110; seg_tbl[15] = 7'b0001110;
        an_tbl[0] = 4'b1110; an_tbl[1] = 4'b1101;
        an_tbl[2] = 4'b1011; an_tbl[3] = 4'b0111;
        nib[0] = 4'd12; nib[1] = 4'd10; nib[2] = 4'd15; nib[3] = 4'd14;

        n_checks = 0;
        n_errors = 0;
        k = 0;
        rst_n = 1'b0;
        set_data(4'd12, 4'd10, 4'd15, 4'd14);

        // Reset hold
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("rst_hold_an",  {4'b0, bus.o_Anodo},     8'h0F);
            chk("rst_hold_seg", {1'b0, bus.o_Segmentos}, 8'h7F);
        end

        // Release between edges, then scan 64 cycles checking order, dwell, one-hot
        rst_n = 1'b1;
        k = 0;
        run_len = 0;
        prev_an = 4'b1110;
        for (int i = 0; i < 64; i++) begin
            tick();
            chk("scan_an",  {4'b0, bus.o_Anodo},     {4'b0, an_tbl[digit_of(k)]});
            chk("scan_seg", {1'b0, bus.o_Segmentos}, {1'b0, seg_tbl[nib[digit_of(k)]]});
            chk("onehot",   8'($countones(~bus.o_Anodo)), 8'd1);
            if (bus.o_Anodo != prev_an) begin
                chk("dwell", 8'(run_len), 8'(P_DIV));
                run_len = 0;
            end
            prev_an = bus.o_Anodo;
            run_len = run_len + 1;
        end

        // Decoder sweep: all inputs equal, held a full frame
        for (int v = 0; v < 16; v++) begin
            set_data(4'(v), 4'(v), 4'(v), 4'(v));
            for (int c = 0; c < 4 * int'(P_DIV); c++) begin
                tick();
                chk("sweep_seg", {1'b0, bus.o_Segmentos}, {1'b0, seg_tbl[v]});
                chk("sweep_an",  {4'b0, bus.o_Anodo},     {4'b0, an_tbl[digit_of(k)]});
            end
        end

        // Async reset while digit 2 is lit
        set_data(4'd12, 4'd10, 4'd15, 4'd14);
        for (int g = 0; g < 32 && digit_of(k) != 2; g++) tick();
        chk("pre_async_an", {4'b0, bus.o_Anodo}, {4'b0, an_tbl[2]});
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_an",  {4'b0, bus.o_Anodo},     8'h0F);
        chk("async_seg", {1'b0, bus.o_Segmentos}, 8'h7F);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("async_hold_an", {4'b0, bus.o_Anodo}, 8'h0F);
        end

        // Restart at digit 0, live update of Datos1, then full dwell
        rst_n = 1'b1;
        k = 0;
        tick();
        chk("restart_an",  {4'b0, bus.o_Anodo},     8'h0E);
        chk("restart_seg", {1'b0, bus.o_Segmentos}, {1'b0, seg_tbl[12]});
        bus.i_Datos1 = 4'd3;
        tick();
        chk("live_seg", {1'b0, bus.o_Segmentos}, 8'b0011_0000);
        chk("live_an",  {4'b0, bus.o_Anodo},     8'h0E);
        tick();
        tick();
        chk("restart_dwell_an", {4'b0, bus.o_Anodo}, 8'h0E);
        tick();
        chk("restart_next_an",  {4'b0, bus.o_Anodo},     8'h0D);
        chk("restart_next_seg", {1'b0, bus.o_Segmentos}, {1'b0, seg_tbl[10]});

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
